// File: rtl/xcrypt_comparator_pkg.sv
// rtl/xcrypt_comparator_pkg.sv - shared constants and FSM encoding for the hash comparator
package xcrypt_comparator_pkg;

    localparam int HASH_NUM_MSB_DEF   = 9;
    localparam int HASH_COUNT_MSB_DEF = HASH_NUM_MSB_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CMP,
        ST_DONE,
        ST_APPLY,
        ST_WAIT_NEG
    } state_t;

endpackage

// File: rtl/xcrypt_comparator_bram.sv
// rtl/xcrypt_comparator_bram.sv - four-lane byte-write, registered-read dual-port comparator table
module xcrypt_comparator_bram
    import xcrypt_comparator_pkg::*;
#(
    parameter int AW = HASH_NUM_MSB_DEF + 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [1:0]    wr_lane,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    localparam int DEPTH = 1 << AW;

    // One RAM per byte lane so each maps onto a plain byte-wide block RAM
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (wr_en && wr_lane == 2'(l)) begin
                mem[wr_addr] <= wr_data;
            end
            q <= mem[rd_addr];
        end

        assign rd_data[8*l +: 8] = q;
    end

endmodule

// File: rtl/xcrypt_comparator.sv
// rtl/xcrypt_comparator.sv - binary-search lookup of computed hash words in a sorted comparator table
module xcrypt_comparator
    import xcrypt_comparator_pkg::*;
#(
    parameter int HASH_NUM_MSB   = HASH_NUM_MSB_DEF,
    parameter int HASH_COUNT_MSB = HASH_NUM_MSB + 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    new_cmp_config,
    output logic                    cmp_config_applied,
    input  logic [HASH_COUNT_MSB:0] hash_count,
    input  logic [HASH_NUM_MSB+2:0] cfg_wr_addr,
    input  logic                    cfg_wr_en,
    input  logic [7:0]              cfg_din,
    input  logic [31:0]             cmp_data,
    input  logic                    cmp_start,
    output logic                    cmp_ready,
    output logic                    result_valid,
    output logic                    result_found,
    output logic [HASH_NUM_MSB:0]   result_hash_num,
    input  logic                    result_rd_en
);

    localparam int IW = HASH_NUM_MSB + 1;
    localparam int SW = HASH_COUNT_MSB + 2;

    state_t               state, state_next;
    logic [31:0]          key;
    logic signed [SW-1:0] lo, hi, mid, mid_w, lo_next, hi_next;
    logic                 found;
    logic                 cfg_wr_en_d1;
    logic [31:0]          rdata;
    logic                 start_acc;

    xcrypt_comparator_bram #(.AW(IW)) u_bram (
        .clk     (CLK),
        .wr_en   (cfg_wr_en),
        .wr_lane (cfg_wr_addr[1:0]),
        .wr_addr (cfg_wr_addr[HASH_NUM_MSB+2:2]),
        .wr_data (cfg_din),
        .rd_addr (mid_w[IW-1:0]),
        .rd_data (rdata)
    );

    // lo+hi stays non-negative while a probe is pending, so the shift is a plain halving
    assign mid_w = (lo + hi) >>> 1;

    assign cmp_ready = (state == ST_IDLE) & ~result_valid & ~new_cmp_config
                     & ~cfg_wr_en & ~cfg_wr_en_d1;
    assign start_acc          = cmp_start & cmp_ready;
    assign cmp_config_applied = (state == ST_APPLY);

    always_comb begin
        lo_next = lo;
        hi_next = hi;
        if (rdata < key) begin
            lo_next = mid + SW'(1);
        end else if (rdata > key) begin
            hi_next = mid - SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (new_cmp_config && !result_valid) begin
                    state_next = ST_APPLY;
                end else if (start_acc) begin
                    state_next = (hash_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ:     state_next = ST_CMP;
            ST_CMP: begin
                if (rdata == key || lo_next > hi_next) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_READ;
                end
            end
            ST_DONE:     state_next = ST_IDLE;
            ST_APPLY:    state_next = ST_WAIT_NEG;
            ST_WAIT_NEG: begin
                if (!new_cmp_config) begin
                    state_next = ST_IDLE;
                end
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            key             <= '0;
            lo              <= '0;
            hi              <= '0;
            mid             <= '0;
            found           <= 1'b0;
            cfg_wr_en_d1    <= 1'b0;
            result_valid    <= 1'b0;
            result_found    <= 1'b0;
            result_hash_num <= '0;
        end else begin
            cfg_wr_en_d1 <= cfg_wr_en;
            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        key   <= cmp_data;
                        lo    <= '0;
                        hi    <= $signed({1'b0, hash_count}) - SW'(1);
                        found <= 1'b0;
                    end
                end
                ST_READ: mid <= mid_w;
                ST_CMP: begin
                    lo    <= lo_next;
                    hi    <= hi_next;
                    found <= (rdata == key);
                end
                default: ;
            endcase

            if (state == ST_DONE) begin
                result_valid    <= 1'b1;
                result_found    <= found;
                result_hash_num <= found ? mid[IW-1:0] : '0;
            end else if (result_rd_en && result_valid) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xcrypt_comparator.sv
// tb/tb_xcrypt_comparator.sv - directed vector bench for xcrypt_comparator
module tb_xcrypt_comparator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        new_cmp_config;
    logic        cmp_config_applied;
    logic [10:0] hash_count;
    logic [11:0] cfg_wr_addr;
    logic        cfg_wr_en;
    logic [7:0]  cfg_din;
    logic [31:0] cmp_data;
    logic        cmp_start;
    logic        cmp_ready;
    logic        result_valid;
    logic        result_found;
    logic [9:0]  result_hash_num;
    logic        result_rd_en;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    xcrypt_comparator dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .new_cmp_config     (new_cmp_config),
        .cmp_config_applied (cmp_config_applied),
        .hash_count         (hash_count),
        .cfg_wr_addr        (cfg_wr_addr),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_din            (cfg_din),
        .cmp_data           (cmp_data),
        .cmp_start          (cmp_start),
        .cmp_ready          (cmp_ready),
        .result_valid       (result_valid),
        .result_found       (result_found),
        .result_hash_num    (result_hash_num),
        .result_rd_en       (result_rd_en)
    );

    typedef struct {
        int          tbl;
        logic [31:0] data;
        logic        found;
        logic [9:0]  num;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_word(input int idx, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            cfg_wr_addr = 12'(idx * 4 + b);
            cfg_din     = w[8*b +: 8];
            cfg_wr_en   = 1'b1;
            @(posedge CLK); #1;
        end
        cfg_wr_en = 1'b0;
    endtask

    task automatic load_table(input int tbl);
        int pulses;
        logic [31:0] small_tbl [3];
        small_tbl[0] = 32'h0000_0010;
        small_tbl[1] = 32'h0000_1000;
        small_tbl[2] = 32'h8000_0000;
        pulses = 0;
        @(posedge CLK); #1;
        new_cmp_config = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            pulses += int'(cmp_config_applied);
        end
        check($sformatf("reload%0d_pulses", tbl), pulses, 1);
        @(posedge CLK); #1;
        new_cmp_config = 1'b0;
        case (tbl)
            0: begin
                hash_count = 11'd3;
                for (int i = 0; i < 3; i++) write_word(i, small_tbl[i]);
            end
            1: begin
                hash_count = 11'd1024;
                for (int i = 0; i < 1024; i++) write_word(i, 32'(i * 4));
            end
            default: hash_count = 11'd0;
        endcase
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (cmp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", cmp_ready, 1);
    endtask

    // Launches one search; lat counts clocks from the accepting edge to result_valid
    task automatic search(input logic [31:0] d, output bit got_valid, output int lat);
        bit ok;
        got_valid = 1'b0;
        lat = 0;
        wait_ready(ok);
        if (ok) begin
            cmp_data  = d;
            cmp_start = 1'b1;
            @(posedge CLK); #1;
            cmp_start = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge CLK);
                lat++;
                @(negedge CLK);
                if (result_valid) begin
                    got_valid = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic consume();
        result_rd_en = 1'b1;
        @(posedge CLK); #1;
        result_rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   got;
        int   lat;
        int   cur;
        int   pulses;
        int   bad;

        vecs.push_back('{0, 32'h0000_1000, 1'b1, 10'd1,    3});
        vecs.push_back('{0, 32'h0000_000F, 1'b0, 10'd0,    5});
        vecs.push_back('{0, 32'h0000_0011, 1'b0, 10'd0,    5});
        vecs.push_back('{0, 32'hFFFF_FFFF, 1'b0, 10'd0,    5});
        vecs.push_back('{0, 32'h0000_0010, 1'b1, 10'd0,    5});
        vecs.push_back('{0, 32'h8000_0000, 1'b1, 10'd2,    5});
        vecs.push_back('{1, 32'd0,         1'b1, 10'd0,    21});
        vecs.push_back('{1, 32'd4092,      1'b1, 10'd1023, 23});
        vecs.push_back('{1, 32'd4093,      1'b0, 10'd0,    23});
        vecs.push_back('{1, 32'd2,         1'b0, 10'd0,    21});
        vecs.push_back('{2, 32'd0,         1'b0, 10'd0,    1});
        vecs.push_back('{2, 32'h1234_5678, 1'b0, 10'd0,    1});

        RESET          = 1'b1;
        new_cmp_config = 1'b0;
        hash_count     = '0;
        cfg_wr_addr    = '0;
        cfg_wr_en      = 1'b0;
        cfg_din        = '0;
        cmp_data       = '0;
        cmp_start      = 1'b0;
        result_rd_en   = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_cmp_ready",       cmp_ready,          1);
        check("rst_result_valid",    result_valid,       0);
        check("rst_result_found",    result_found,       0);
        check("rst_result_hash_num", result_hash_num,    0);
        check("rst_applied",         cmp_config_applied, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].tbl != cur) begin
                load_table(vecs[i].tbl);
                cur = vecs[i].tbl;
            end
            search(vecs[i].data, got, lat);
            check($sformatf("v%0d_valid", i), got, 1);
            if (got) begin
                check($sformatf("v%0d_found", i), result_found,    vecs[i].found);
                check($sformatf("v%0d_num", i),   result_hash_num, vecs[i].num);
                check($sformatf("v%0d_lat", i),   lat,             vecs[i].lat);
                consume();
            end
        end

        // Reload request arriving mid-search, with the result held back
        load_table(0);
        wait_ready(got);
        if (got) begin
            cmp_data  = 32'h0000_1000;
            cmp_start = 1'b1;
            @(posedge CLK); #1;
            cmp_start      = 1'b0;
            new_cmp_config = 1'b1;
            pulses = 0;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge CLK);
                pulses += int'(cmp_config_applied);
                if (result_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check("mid_reload_valid", got, 1);
            bad = 0;
            repeat (20) begin
                @(negedge CLK);
                pulses += int'(cmp_config_applied);
                if (!result_valid || cmp_ready || !result_found || result_hash_num != 10'd1) bad++;
            end
            check("backpressure_stable", bad, 0);
            check("backpressure_ready",  cmp_ready, 0);
            check("mid_reload_found",    result_found, 1);
            check("mid_reload_num",      result_hash_num, 1);
            check("no_apply_before_read", pulses, 0);
            consume();
            pulses = 0;
            repeat (10) begin
                @(negedge CLK);
                pulses += int'(cmp_config_applied);
            end
            check("apply_after_read", pulses, 1);
            new_cmp_config = 1'b0;
            repeat (3) @(posedge CLK);
            #1;
        end

        // Reset while the FSM sits in READ
        wait_ready(got);
        if (got) begin
            cmp_data  = 32'h0000_1000;
            cmp_start = 1'b1;
            @(posedge CLK); #1;
            cmp_start = 1'b0;
            RESET     = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            check("rst_read_valid", result_valid, 0);
            check("rst_read_ready", cmp_ready,    1);
            RESET = 1'b0;
            bad = 0;
            repeat (10) begin
                @(negedge CLK);
                if (result_valid) bad++;
            end
            check("rst_read_no_result", bad, 0);
            search(32'h8000_0000, got, lat);
            check("post_rst_valid", got, 1);
            if (got) begin
                check("post_rst_found", result_found,    1);
                check("post_rst_num",   result_hash_num, 2);
                check("post_rst_lat",   lat,             5);
                consume();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
